// File: rtl/tree_accumulator.sv
// Registered binary adder tree over NO_IN signed samples, followed by a framed
// accumulator that emits one (optionally saturated) sum per frame with a sticky overflow flag.
module tree_accumulator #(
  parameter int IN_BITWIDTH  = 8,
  parameter int OUT_BITWIDTH = 16,
  parameter int NO_IN        = 5,
  parameter int SATURATE     = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                vld_in,
  input  logic                                first,
  input  logic                                last,
  input  logic [NO_IN-1:0][IN_BITWIDTH-1:0]   data_in,
  output logic                                vld_out,
  output logic signed [OUT_BITWIDTH-1:0]      data_out,
  output logic                                ovf
);

  localparam int D  = $clog2(NO_IN);
  localparam int SW = IN_BITWIDTH + D;
  localparam int MSB = OUT_BITWIDTH - 1;
  localparam logic signed [OUT_BITWIDTH-1:0] ACC_MAX = {1'b0, {(OUT_BITWIDTH-1){1'b1}}};
  localparam logic signed [OUT_BITWIDTH-1:0] ACC_MIN = {1'b1, {(OUT_BITWIDTH-1){1'b0}}};

  function automatic int n_at(input int k);
    int n;
    n = NO_IN;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int clamp_idx(input int i);
    return (i < NO_IN) ? i : NO_IN - 1;
  endfunction

  // Level 0 is the input register; level D holds the single tree result.
  logic signed [SW-1:0] lvl_q [0:D][0:NO_IN-1];
  logic signed [SW-1:0] lvl_d [0:D][0:NO_IN-1];
  logic [D:0]           vld_q, first_q, last_q;
  logic [D:0]           vld_d, first_d, last_d;

  always_comb begin
    for (int k = 0; k <= D; k++)
      for (int j = 0; j < NO_IN; j++)
        lvl_d[k][j] = '0;
    for (int j = 0; j < NO_IN; j++)
      lvl_d[0][j] = SW'($signed(data_in[j]));
    for (int k = 1; k <= D; k++) begin
      for (int j = 0; j < NO_IN; j++) begin
        if (2*j + 1 < n_at(k-1))
          lvl_d[k][j] = lvl_q[k-1][clamp_idx(2*j)] + lvl_q[k-1][clamp_idx(2*j+1)];
        else if (2*j < n_at(k-1))
          lvl_d[k][j] = lvl_q[k-1][clamp_idx(2*j)];
      end
    end
    vld_d[0]   = vld_in;
    first_d[0] = first;
    last_d[0]  = last;
    for (int k = 1; k <= D; k++) begin
      vld_d[k]   = vld_q[k-1];
      first_d[k] = first_q[k-1];
      last_d[k]  = last_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= D; k++)
        for (int j = 0; j < NO_IN; j++)
          lvl_q[k][j] <= '0;
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      lvl_q   <= lvl_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  logic                           t_vld, t_first, t_last;
  logic signed [OUT_BITWIDTH-1:0] t_ext;

  assign t_vld   = vld_q[D];
  assign t_first = first_q[D];
  assign t_last  = last_q[D];
  assign t_ext   = OUT_BITWIDTH'(lvl_q[D][0]);

  logic                           open_q;
  logic signed [OUT_BITWIDTH-1:0] acc_q, acc_d, base;
  logic signed [OUT_BITWIDTH:0]   sum_d;
  logic                           ovf_acc_q, ovf_acc_d, use_acc, ovf_now;
  logic                           vld_out_q, ovf_q;
  logic signed [OUT_BITWIDTH-1:0] data_out_q;

  // open_q low means the next valid beat starts a fresh frame.
  always_comb begin
    use_acc   = open_q & ~t_first;
    base      = use_acc ? acc_q : '0;
    sum_d     = {base[MSB], base} + {t_ext[MSB], t_ext};
    ovf_now   = sum_d[OUT_BITWIDTH] ^ sum_d[MSB];
    acc_d     = sum_d[MSB:0];
    if (ovf_now && (SATURATE != 0))
      acc_d = sum_d[OUT_BITWIDTH] ? ACC_MIN : ACC_MAX;
    ovf_acc_d = ovf_now | (use_acc & ovf_acc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q     <= 1'b0;
      acc_q      <= '0;
      ovf_acc_q  <= 1'b0;
      vld_out_q  <= 1'b0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_out_q <= t_vld & t_last;
      if (t_vld) begin
        acc_q     <= acc_d;
        ovf_acc_q <= ovf_acc_d;
        open_q    <= ~t_last;
        if (t_last) begin
          data_out_q <= acc_d;
          ovf_q      <= ovf_acc_d;
        end
      end
    end
  end

  assign vld_out  = vld_out_q;
  assign data_out = data_out_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_tree_accumulator.sv
// Bench for tree_accumulator: three instances (saturating and wrapping NO_IN=5, saturating NO_IN=3)
// checked every cycle against a frame-level arithmetic model, plus directed vectors and sequences.
module tb_tree_accumulator;

  localparam int OW   = 12;
  localparam int MAXE = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld = 1'b0, fi = 1'b0, la = 1'b0;
  logic [4:0][7:0] din5 = '0;
  logic [2:0][7:0] din3;
  assign din3 = din5[2:0];

  logic vo_s, vo_w, vo_o, ov_s, ov_w, ov_o;
  logic signed [OW-1:0] do_s, do_w, do_o;

  tree_accumulator #(.IN_BITWIDTH(8), .OUT_BITWIDTH(OW), .NO_IN(5), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .vld_in(vld), .first(fi), .last(la), .data_in(din5),
    .vld_out(vo_s), .data_out(do_s), .ovf(ov_s));
  tree_accumulator #(.IN_BITWIDTH(8), .OUT_BITWIDTH(OW), .NO_IN(5), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .vld_in(vld), .first(fi), .last(la), .data_in(din5),
    .vld_out(vo_w), .data_out(do_w), .ovf(ov_w));
  tree_accumulator #(.IN_BITWIDTH(8), .OUT_BITWIDTH(OW), .NO_IN(3), .SATURATE(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .vld_in(vld), .first(fi), .last(la), .data_in(din3),
    .vld_out(vo_o), .data_out(do_o), .ovf(ov_o));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, edge_cnt = 0;
  logic signed [7:0] smp [5];

  // Model state per instance: 0 = sat/5, 1 = wrap/5, 2 = sat/3
  int  m_acc [3];
  bit  m_open [3];
  bit  m_ovf [3];
  bit  sv [3][MAXE];
  int  sd [3][MAXE];
  bit  so [3][MAXE];
  int  hd [3];
  bit  ho [3];

  typedef struct {
    int nb;
    int val;
    int gap;
    int es;
    bit os;
    int ew;
    bit ow;
  } vec_t;
  vec_t tbl [7];

  function automatic int nin(input int m);  return (m == 2) ? 3 : 5; endfunction
  function automatic int lat(input int m);  return (m == 2) ? 3 : 4; endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic void model_beat(input int m, input bit f, input bit l, input int e);
    int s, base, raw, res;
    bit o, use_acc;
    s = 0;
    for (int j = 0; j < nin(m); j++) s += int'(smp[j]);
    use_acc = m_open[m] && !f;
    base = use_acc ? m_acc[m] : 0;
    raw = base + s;
    o = (raw > 2047) || (raw < -2048);
    res = raw;
    if (o) begin
      if (m != 1) res = (raw > 0) ? 2047 : -2048;
      else        res = (((raw + 2048) % 4096) + 4096) % 4096 - 2048;
    end
    m_ovf[m]  = o || (use_acc && m_ovf[m]);
    m_acc[m]  = res;
    m_open[m] = !l;
    if (l && (e + lat(m) < MAXE)) begin
      sv[3'(m)][e + lat(m)] = 1'b1;
      sd[m][e + lat(m)] = res;
      so[m][e + lat(m)] = m_ovf[m];
    end
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 3; m++) begin
      m_acc[m] = 0; m_open[m] = 1'b0; m_ovf[m] = 1'b0;
      hd[m] = 0; ho[m] = 1'b0;
      for (int e = edge_cnt + 1; e < MAXE; e++) sv[m][e] = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    int ad;
    bit av, ao;
    for (int m = 0; m < 3; m++) begin
      case (m)
        0:       begin av = vo_s; ad = int'(do_s); ao = ov_s; end
        1:       begin av = vo_w; ad = int'(do_w); ao = ov_w; end
        default: begin av = vo_o; ad = int'(do_o); ao = ov_o; end
      endcase
      if (edge_cnt < MAXE && sv[m][edge_cnt]) begin
        hd[m] = sd[m][edge_cnt];
        ho[m] = so[m][edge_cnt];
      end
      chk($sformatf("model u%0d vld_out e%0d", m, edge_cnt), int'(av),
          (edge_cnt < MAXE) ? int'(sv[m][edge_cnt]) : 0);
      chk($sformatf("model u%0d data_out e%0d", m, edge_cnt), ad, hd[m]);
      chk($sformatf("model u%0d ovf e%0d", m, edge_cnt), int'(ao), int'(ho[m]));
    end
  endtask

  task automatic step(input bit v, input bit f, input bit l);
    vld = v; fi = f; la = l;
    for (int j = 0; j < 5; j++) din5[j] = smp[j];
    if (rst_n && v)
      for (int m = 0; m < 3; m++) model_beat(m, f, l, edge_cnt + 1);
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_smp();
    for (int j = 0; j < 5; j++) smp[j] = 8'($urandom_range(255));
  endtask

  task automatic idle();
    rand_smp();
    step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic set_smp(input int v);
    for (int j = 0; j < 5; j++) smp[j] = 8'(v);
  endtask

  int pulses, dval, lat_o, lat_s, first_idx;
  bit got_v [10];
  int got_d [10];

  initial begin
    tbl[0] = '{1,  127, 0,   635, 1'b0,   635, 1'b0};
    tbl[1] = '{3, -128, 2, -1920, 1'b0, -1920, 1'b0};
    tbl[2] = '{4,  127, 0,  2047, 1'b1, -1556, 1'b1};
    tbl[3] = '{1,    1, 0,     5, 1'b0,     5, 1'b0};
    tbl[4] = '{4, -128, 0, -2048, 1'b1,  1536, 1'b1};
    tbl[5] = '{2,  100, 1,  1000, 1'b0,  1000, 1'b0};
    tbl[6] = '{5, -100, 0, -2048, 1'b1,  1596, 1'b1};
    set_smp(0);

    // Held in reset with valid traffic: every output stays 0
    @(negedge clk);
    repeat (5) begin
      rand_smp();
      step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    rst_n = 1'b1;
    model_reset();
    repeat (2) idle();

    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < tbl[i].nb; b++) begin
        set_smp(tbl[i].val);
        step(1'b1, b == 0, b == tbl[i].nb - 1);
        if (b < tbl[i].nb - 1) repeat (tbl[i].gap) idle();
      end
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
        idle();
        if (vo_s) begin
          pulses++;
          if (pulses == 1) begin
            chk($sformatf("tbl%0d sat data", i), int'(do_s), tbl[i].es);
            chk($sformatf("tbl%0d sat ovf", i), int'(ov_s), int'(tbl[i].os));
            chk($sformatf("tbl%0d wrap vld", i), int'(vo_w), 1);
            chk($sformatf("tbl%0d wrap data", i), int'(do_w), tbl[i].ew);
            chk($sformatf("tbl%0d wrap ovf", i), int'(ov_w), int'(tbl[i].ow));
          end
        end
      end
      chk($sformatf("tbl%0d pulse count", i), pulses, 1);
    end

    // Odd width: samples 1,2,4 -> 7 at latency 3 (NO_IN=3) and 4 (NO_IN=5)
    smp[0] = 8'sd1; smp[1] = 8'sd2; smp[2] = 8'sd4; smp[3] = 8'sd0; smp[4] = 8'sd0;
    step(1'b1, 1'b1, 1'b1);
    lat_o = -1; lat_s = -1;
    for (int k = 0; k < 8; k++) begin
      idle();
      if (vo_o && lat_o < 0) begin lat_o = k + 1; dval = int'(do_o); end
      if (vo_s && lat_s < 0) lat_s = k + 1;
    end
    chk("odd latency", lat_o, 3);
    chk("odd data", dval, 7);
    chk("five latency", lat_s, 4);

    // Back-to-back frames {10,20} then {-3}
    set_smp(10);  step(1'b1, 1'b1, 1'b0);
    set_smp(20);  step(1'b1, 1'b0, 1'b1);
    set_smp(-3);  step(1'b1, 1'b1, 1'b1);
    pulses = 0; first_idx = -1;
    for (int k = 0; k < 10; k++) begin
      idle();
      got_v[k] = vo_s;
      got_d[k] = int'(do_s);
      if (vo_s) begin
        if (pulses == 0) first_idx = k;
        pulses++;
      end
    end
    chk("b2b pulse count", pulses, 2);
    if (first_idx >= 0 && first_idx < 9) begin
      chk("b2b first sum", got_d[first_idx], 150);
      chk("b2b adjacent pulse", int'(got_v[first_idx+1]), 1);
      chk("b2b second sum", got_d[first_idx+1], -15);
    end

    // first mid-frame: the 50+50 partial is abandoned
    set_smp(50); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    set_smp(3);  step(1'b1, 1'b1, 1'b0);
    set_smp(4);  step(1'b1, 1'b0, 1'b1);
    pulses = 0; dval = 0;
    for (int k = 0; k < 10; k++) begin
      idle();
      if (vo_s) begin pulses++; dval = int'(do_s); end
    end
    chk("restart pulse count", pulses, 1);
    chk("restart sum", dval, 35);

    // Reset while two beats of a frame are in the tree
    set_smp(9); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    model_reset();
    repeat (2) idle();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      idle();
      if (vo_s || vo_w || vo_o) pulses++;
    end
    chk("reset mid-frame pulses", pulses, 0);

    // Random framing, bubbles and data against the model
    repeat (400) begin
      rand_smp();
      step($urandom_range(9) < 7, $urandom_range(4) == 0, $urandom_range(3) == 0);
    end
    repeat (6) idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tree_accumulator.md
# tree_accumulator

Parametrised, pipelined adder-tree accumulator with an arbitrary input count (not restricted to powers of two), valid qualification, explicit first/last framing, and selectable saturating or wrapping accumulation. Each cycle it reduces NO_IN signed samples through a registered binary tree, then accumulates the tree result over a framed sequence of beats. It emits one result per frame with an overflow flag. It sits behind the ternary multiply/select stage and sums partial products across input channels and kernel taps.

## Interface
- IN_BITWIDTH, 8, width of each signed input sample
- OUT_BITWIDTH, 16, width of the signed accumulator and data_out; must satisfy OUT_BITWIDTH >= IN_BITWIDTH + D
- NO_IN, 5, number of samples per beat, >= 1
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
- Derived: D = ceil(log2(NO_IN)), the number of tree stages (D = 0 when NO_IN = 1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- vld_in  in  1  beat valid
- first  in  1  first beat of a frame; sampled only with vld_in
- last  in  1  last beat of a frame; sampled only with vld_in
- data_in  in  NO_IN x IN_BITWIDTH  signed samples, index 0..NO_IN-1
- vld_out  out  1  one-cycle pulse, result valid
- data_out  out  OUT_BITWIDTH  signed frame sum, held until the next vld_out
- ovf  out  1  overflow occurred in this frame; qualified by vld_out and held with data_out

## Operation
- **Tree.** Stage k (1..D) pairs elements 2j and 2j+1 of stage k-1 into a signed sum of width IN_BITWIDTH+k.
  - An odd leftover element is sign-extended and registered unchanged.
  - Stage D has one element.
  - vld, first and last are delayed alongside the data through D registers.
- **Accumulator.** An OUT_BITWIDTH register acc receives the sign-extended tree output t, and only on valid tree beats.
  - base = 0 if the beat is tagged first, or if the previous valid beat was tagged last, or if this is the first beat since reset. Otherwise base = acc.
  - sum = base + t, computed at OUT_BITWIDTH+1 bits.
  - Overflow means sum lies outside [-2^(OUT_BITWIDTH-1), 2^(OUT_BITWIDTH-1)-1].
  - SATURATE=1: the result is clamped to the nearest bound and accumulation continues from the clamped value.
  - SATURATE=0: the result is truncated (wrap).
  - ovf_acc (sticky) = overflow OR (ovf_acc if base = acc, else 0).
- **Output.** On a valid tree beat tagged last: data_out <= result, ovf <= ovf_acc_next, vld_out <= 1. Otherwise vld_out <= 0 and data_out/ovf hold.
- **Boundary cases:**
  - first and last on the same beat: single-beat frame; result = t.
  - first while a frame is open: the partial sum and ovf_acc are discarded and a new frame starts. No output for the abandoned frame.
  - vld_in low: bubble. The tree propagates invalid and the accumulator holds. Any number of bubbles is allowed inside a frame.
  - Back-to-back frames: a last beat followed immediately by the next frame's beat is supported at full rate.
  - first/last with vld_in low: ignored.

## Timing
- Throughput: one beat per cycle, no backpressure.
- Latency: a last beat sampled at edge n gives vld_out high after edge n+D+1. That is D+1 cycles; 4 cycles for NO_IN=5.
- Reset (rst_n low, asynchronous): all stage registers, delayed vld/first/last, acc, ovf_acc, data_out, ovf and vld_out are cleared to 0.
  - In-flight beats are discarded.
  - The first valid beat after release starts a new frame regardless of first.
- The reset release is synchronised externally; the block itself has no reset synchroniser.

## Test plan
- **Reset:** hold rst_n low, drive vld_in=1 with random data -> vld_out=0, data_out=0, ovf=0 throughout. After release, the first vld_out appears only after a complete framed beat.
- **Single-beat frame** (NO_IN=5, IN=8, OUT=12): all samples 127, first=last=1 at edge 0 -> vld_out pulse after edge 4, data_out=635, ovf=0.
- **Multi-beat with bubbles:** three valid beats of all -128 separated by 2 idle cycles each, first on beat 1, last on beat 3 -> data_out=-1920, ovf=0, exactly one vld_out pulse.
- **Overflow:** four beats of all 127 (total 2540), OUT=12.
  - SATURATE=1 -> data_out=2047, ovf=1.
  - SATURATE=0 -> data_out=-1556, ovf=1.
  - The next frame of a single beat of all 1 -> data_out=5, ovf=0.
- **Framing:**
  - Back-to-back frames {10,20} then {-3} with no gap -> consecutive pulses of 150 and -15 (samples all equal per beat, NO_IN=5).
  - first asserted mid-frame -> the partial sum is discarded and only the restarted frame is reported.
- **Odd width / reset mid-frame:**
  - NO_IN=3 with samples 1,2,4 -> data_out=7 at latency 3.
  - With NO_IN=5, pulse rst_n low while 2 beats are in the tree -> no vld_out from those beats.
